// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor.
//   MODE_BIMODAL / MODE_GSHARE : values for the MODE parameter of the top level.
//   bp_state_e                 : controller state (table initialisation sweep, then running).
//   init_ctr()                 : weakly-not-taken reset value for a counter of a given width.
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bp_state_e;

  // Largest value whose MSB is still 0, i.e. the weakest not-taken state.
  function automatic int init_ctr(input int ctr_width);
    return (1 << (ctr_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational next-value logic for one saturating counter.
//   cur   in  CTR_WIDTH  current counter value
//   taken in  1          resolved direction (1 = count up, 0 = count down)
//   nxt   out CTR_WIDTH  next counter value, clamped at 0 and all-ones
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] cur,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] nxt
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN = '0;

  // Saturation is checked before the add/subtract so the value never wraps.
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_MAX) nxt = cur + CTR_WIDTH'(1);
    end else begin
      if (cur != CTR_MIN) nxt = cur - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: pattern history table of saturating counters with
// bimodal or gshare indexing and a speculative global history register.
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-low reset
//   predictAddr     in   fetch PC index
//   predictValid    in   prediction request
//   prediction      out  registered predicted direction
//   predictHist     out  registered GHR snapshot used for that prediction
//   predictReady    out  table initialised, requests accepted
//   updateAddr      in   PC index of the resolved branch
//   updateHist      in   predictHist value that travelled with the branch
//   branchTaken     in   resolved direction
//   update          in   resolved-branch strobe
//   mispredict      in   qualifies update; restores GHR and bumps the counter
//   mispredictCount out  saturating count of accepted mispredicts
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_WIDTH = 6,
  parameter int MODE       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] predictAddr,
  input  logic                  predictValid,
  output logic                  prediction,
  output logic [HIST_WIDTH-1:0] predictHist,
  output logic                  predictReady,
  input  logic [ADDR_WIDTH-1:0] updateAddr,
  input  logic [HIST_WIDTH-1:0] updateHist,
  input  logic                  branchTaken,
  input  logic                  update,
  input  logic                  mispredict,
  output logic [CNT_WIDTH-1:0]  mispredictCount
);

  localparam int                    NUM_ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [CTR_WIDTH-1:0]  INIT_CTR    = CTR_WIDTH'(init_ctr(CTR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;

  bp_state_e             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] sweep_ptr_reg;
  logic [HIST_WIDTH-1:0] ghr_reg, ghr_next;
  logic                  prediction_reg;
  logic [HIST_WIDTH-1:0] predict_hist_reg;
  logic [CNT_WIDTH-1:0]  mispredict_count_reg;

  logic [CTR_WIDTH-1:0]  pht [NUM_ENTRIES];

  logic [ADDR_WIDTH-1:0] predict_index, update_index;
  logic                  predict_bit;
  logic [CTR_WIDTH-1:0]  update_ctr_next;
  logic                  run, predict_fire, update_fire, recover;

  // Appends a new youngest bit and drops the oldest one.
  function automatic logic [HIST_WIDTH-1:0] shift_in(input logic [HIST_WIDTH-1:0] hist,
                                                     input logic                  bit_in);
    return HIST_WIDTH'({hist, bit_in});
  endfunction

  generate
    if (MODE == MODE_GSHARE) begin : g_gshare
      // GHR is zero-extended to the index width before the XOR.
      assign predict_index = predictAddr ^ ADDR_WIDTH'(ghr_reg);
      assign update_index  = updateAddr ^ ADDR_WIDTH'(updateHist);
    end else begin : g_bimodal
      assign predict_index = predictAddr;
      assign update_index  = updateAddr;
    end
  endgenerate

  assign run          = (state_reg == ST_RUN);
  assign predict_fire = run & predictValid;
  assign update_fire  = run & update;
  assign recover      = update_fire & mispredict;

  // Read happens from the current array contents, so a same-cycle update to
  // the same entry is not visible to this prediction.
  assign predict_bit = pht[predict_index][CTR_WIDTH-1];

  bp_sat_counter #(.CTR_WIDTH(CTR_WIDTH)) u_sat_counter (
    .cur   (pht[update_index]),
    .taken (branchTaken),
    .nxt   (update_ctr_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: if (sweep_ptr_reg == LAST_ENTRY) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Recovery is applied last so it overrides the speculative shift.
  always_comb begin
    ghr_next = ghr_reg;
    if (predict_fire) ghr_next = shift_in(ghr_reg, predict_bit);
    if (recover)      ghr_next = shift_in(updateHist, branchTaken);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg            <= ST_INIT;
      sweep_ptr_reg        <= '0;
      ghr_reg              <= '0;
      prediction_reg       <= 1'b0;
      predict_hist_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ghr_reg   <= ghr_next;
      if (state_reg == ST_INIT) sweep_ptr_reg <= sweep_ptr_reg + ADDR_WIDTH'(1);
      if (predict_fire) begin
        prediction_reg   <= predict_bit;
        predict_hist_reg <= ghr_reg;
      end
      if (recover && (mispredict_count_reg != CNT_MAX)) begin
        mispredict_count_reg <= mispredict_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Single write port: the sweep owns it during INIT, resolved updates afterwards.
  // The table itself carries no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (state_reg == ST_INIT) begin
      pht[sweep_ptr_reg] <= INIT_CTR;
    end else if (update_fire) begin
      pht[update_index] <= update_ctr_next;
    end
  end

  assign prediction      = prediction_reg;
  assign predictHist     = predict_hist_reg;
  assign predictReady    = run;
  assign mispredictCount = mispredict_count_reg;

endmodule
